// File: rtl/seq_signed_div.sv
// Iterative signed divider: 20-bit dividend / 5-bit divisor -> 15-bit quotient, 5-bit remainder.
// Magnitudes are divided with one radix-2 restoring step per clock, then signs are applied.
// Results are truncating (C semantics); out-of-range quotients saturate and flag overflow.
module seq_signed_div #(
   parameter int unsigned DIVIDEND_W = 20,
   parameter int unsigned DIVISOR_W  = 5,
   parameter int unsigned QUOT_W     = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  div_en,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  div_busy,
   output logic                  div_out_valid,
   output logic [QUOT_W-1:0]     quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero,
   output logic                  overflow
);

   localparam int unsigned           CntW     = $clog2(DIVIDEND_W);
   localparam logic [CntW-1:0]       LastStep = CntW'(DIVIDEND_W - 1);
   // Largest magnitudes representable in the signed quotient
   localparam logic [DIVIDEND_W-1:0] PosLim   = DIVIDEND_W'((64'd1 << (QUOT_W - 1)) - 64'd1);
   localparam logic [DIVIDEND_W-1:0] NegLim   = DIVIDEND_W'(64'd1 << (QUOT_W - 1));
   localparam logic [QUOT_W-1:0]     QSatPos  = {1'b0, {(QUOT_W - 1){1'b1}}};
   localparam logic [QUOT_W-1:0]     QSatNeg  = {1'b1, {(QUOT_W - 1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

   state_t                  state;
   logic [DIVIDEND_W-1:0]   dvd_abs;   // |dividend| shifting out MSB-first, quotient bits shift in
   logic [DIVISOR_W-1:0]    dsr_abs;
   logic [DIVISOR_W-1:0]    part_rem;  // always < |divisor| <= 16, so 5 bits suffice between steps
   logic [CntW-1:0]         step_cnt;
   logic                    sign_q;
   logic                    sign_r;

   logic [DIVISOR_W:0]      shifted;
   logic                    q_bit;
   logic [DIVISOR_W-1:0]    rem_next;
   logic [DIVIDEND_W-1:0]   dvd_next;
   logic                    ovf_calc;
   logic [QUOT_W-1:0]       quot_calc;
   logic [DIVISOR_W-1:0]    rem_calc;
   logic [DIVIDEND_W-1:0]   dividend_abs;
   logic [DIVISOR_W-1:0]    divisor_abs;

   // One restoring step plus the sign/saturation fix applied to the final step's result
   always_comb begin
      shifted  = {part_rem, dvd_abs[DIVIDEND_W-1]};
      q_bit    = (shifted >= {1'b0, dsr_abs});
      // Difference is below |divisor| when kept, so modulo-32 subtraction is exact
      rem_next = q_bit ? (shifted[DIVISOR_W-1:0] - dsr_abs) : shifted[DIVISOR_W-1:0];
      dvd_next = {dvd_abs[DIVIDEND_W-2:0], q_bit};

      ovf_calc = sign_q ? (dvd_next > NegLim) : (dvd_next > PosLim);
      if (ovf_calc) begin
         quot_calc = sign_q ? QSatNeg : QSatPos;
      end else begin
         quot_calc = sign_q ? -dvd_next[QUOT_W-1:0] : dvd_next[QUOT_W-1:0];
      end
      rem_calc = sign_r ? -rem_next : rem_next;

      // Most-negative operands map to 2^(W-1), which still fits unsigned
      dividend_abs = dividend[DIVIDEND_W-1] ? -dividend : dividend;
      divisor_abs  = divisor[DIVISOR_W-1] ? -divisor : divisor;
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= StIdle;
         dvd_abs       <= '0;
         dsr_abs       <= '0;
         part_rem      <= '0;
         step_cnt      <= '0;
         sign_q        <= 1'b0;
         sign_r        <= 1'b0;
         div_busy      <= 1'b0;
         div_out_valid <= 1'b0;
         quotient      <= '0;
         remainder     <= '0;
         div_by_zero   <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (div_en) begin
                  dvd_abs  <= dividend_abs;
                  dsr_abs  <= divisor_abs;
                  part_rem <= '0;
                  step_cnt <= '0;
                  sign_q   <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                  sign_r   <= dividend[DIVIDEND_W-1];
                  div_busy <= 1'b1;
                  if (divisor == '0) begin
                     state         <= StDone;
                     div_out_valid <= 1'b1;
                     quotient      <= '1;
                     remainder     <= dividend[DIVISOR_W-1:0];
                     div_by_zero   <= 1'b1;
                     overflow      <= 1'b0;
                  end else begin
                     state <= StCalc;
                  end
               end
            end
            StCalc: begin
               part_rem <= rem_next;
               dvd_abs  <= dvd_next;
               step_cnt <= step_cnt + 1'b1;
               if (step_cnt == LastStep) begin
                  state         <= StDone;
                  div_out_valid <= 1'b1;
                  quotient      <= quot_calc;
                  remainder     <= rem_calc;
                  div_by_zero   <= 1'b0;
                  overflow      <= ovf_calc;
               end
            end
            StDone: begin
               state         <= StIdle;
               div_busy      <= 1'b0;
               div_out_valid <= 1'b0;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_signed_div.sv
// Self-checking bench for seq_signed_div: directed corner cases, control checks and
// randomized operations compared against an integer-arithmetic reference model.
module tb_seq_signed_div;

   logic        clk;
   logic        rst_n;
   logic        div_en;
   logic [19:0] dividend;
   logic [4:0]  divisor;
   logic        div_busy;
   logic        div_out_valid;
   logic [14:0] quotient;
   logic [4:0]  remainder;
   logic        div_by_zero;
   logic        overflow;

   int n_total = 0;
   int n_bad   = 0;

   seq_signed_div #(
      .DIVIDEND_W (20),
      .DIVISOR_W  (5),
      .QUOT_W     (15)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .div_en        (div_en),
      .dividend      (dividend),
      .divisor       (divisor),
      .div_busy      (div_busy),
      .div_out_valid (div_out_valid),
      .quotient      (quotient),
      .remainder     (remainder),
      .div_by_zero   (div_by_zero),
      .overflow      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: C-style / and %, saturating quotient, fixed divide-by-zero result
   function automatic void model(input int a, input int b, output logic [14:0] q,
                                 output logic [4:0] r, output bit dbz, output bit ovf);
      int qt;
      int rt;
      if (b == 0) begin
         q   = 15'h7FFF;
         r   = a[4:0];
         dbz = 1'b1;
         ovf = 1'b0;
      end else begin
         qt  = a / b;
         rt  = a % b;
         dbz = 1'b0;
         ovf = 1'b0;
         if (qt > 16383) begin
            ovf = 1'b1;
            q   = 15'h3FFF;
         end else if (qt < -16384) begin
            ovf = 1'b1;
            q   = 15'h4000;
         end else begin
            q = qt[14:0];
         end
         r = rt[4:0];
      end
   endfunction

   // Issue one operation, optionally pulse div_en again pulse_at cycles after accept,
   // wait (bounded) for the result and check it plus timing.
   task automatic do_op(input logic signed [19:0] a, input logic signed [4:0] b,
                        input int pulse_at, input string tag);
      logic [14:0] eq;
      logic [4:0]  er;
      bit          edbz;
      bit          eovf;
      int          k;
      int          busy_n;
      int          exp_lat;
      model(int'(a), int'(b), eq, er, edbz, eovf);
      // Valid cycle follows edge E0 directly on divide-by-zero, else edge E20
      exp_lat = edbz ? 0 : 20;
      @(negedge clk);
      div_en   = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      div_en   = 1'b0;
      dividend = 20'($urandom);
      divisor  = 5'($urandom);
      k        = 0;
      busy_n   = 0;
      while (!div_out_valid && k < 40) begin
         if (div_busy) busy_n++;
         if (k == pulse_at) begin
            div_en   = 1'b1;
            dividend = -20'sd5;
            divisor  = 5'sd1;
         end else begin
            div_en = 1'b0;
         end
         @(posedge clk);
         #1;
         k++;
      end
      div_en = 1'b0;
      if (div_busy) busy_n++;
      check_val({tag, "_lat"}, k, exp_lat);
      check_val({tag, "_busy_cycles"}, busy_n, exp_lat + 1);
      check_val({tag, "_quot"}, {17'd0, quotient}, {17'd0, eq});
      check_val({tag, "_rem"}, {27'd0, remainder}, {27'd0, er});
      check_val({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
      check_val({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eovf});
      @(posedge clk);
      #1;
      check_val({tag, "_valid_drop"}, {31'd0, div_out_valid}, 32'd0);
      check_val({tag, "_idle"}, {31'd0, div_busy}, 32'd0);
   endtask

   // Count valid strobes over a window (used to prove nothing extra comes out)
   task automatic count_valids(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (div_out_valid) n++;
      end
   endtask

   initial begin
      int           nv;
      int           sel;
      logic [19:0]  ra;
      logic [4:0]   rb;
      logic [19:0]  dvd_corner [8];
      logic [4:0]   dsr_corner [4];

      dvd_corner[0] = 20'h80000; dvd_corner[1] = 20'h7FFFF;
      dvd_corner[2] = 20'h00000; dvd_corner[3] = 20'hFFFFF;
      dvd_corner[4] = 20'd16383; dvd_corner[5] = -20'sd16384;
      dvd_corner[6] = 20'd16384; dvd_corner[7] = -20'sd16385;
      dsr_corner[0] = 5'h10; dsr_corner[1] = 5'h0F;
      dsr_corner[2] = 5'h01; dsr_corner[3] = 5'h1F;

      rst_n    = 1'b0;
      div_en   = 1'b0;
      dividend = '0;
      divisor  = '0;
      #23;
      check_val("rst_busy", {31'd0, div_busy}, 32'd0);
      check_val("rst_valid", {31'd0, div_out_valid}, 32'd0);
      check_val("rst_quot", {17'd0, quotient}, 32'd0);
      check_val("rst_rem", {27'd0, remainder}, 32'd0);
      check_val("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      check_val("rst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic and sign combinations
      do_op(20'sd1000, 5'sd7, -1, "p_p");
      do_op(-20'sd1000, 5'sd7, -1, "n_p");
      do_op(20'sd1000, -5'sd7, -1, "p_n");
      do_op(-20'sd1000, -5'sd7, -1, "n_n");
      // Overflow and boundaries
      do_op(20'sd524287, 5'sd1, -1, "ovf_pos");
      do_op(-20'sd524288, 5'sd15, -1, "ovf_neg15");
      do_op(-20'sd524288, -5'sd16, -1, "ovf_nn");
      do_op(20'sd16383, 5'sd1, -1, "max_pos");
      do_op(-20'sd16384, 5'sd1, -1, "max_neg");
      do_op(20'sd5, -5'sd16, -1, "small");
      // Divide by zero, then a normal result must clear dbz
      do_op(20'sd12345, 5'sd0, -1, "dbz");
      do_op(20'sd1000, 5'sd7, -1, "after_dbz");

      // div_en pulsed mid-CALC is ignored: exactly one result, no follow-on op
      do_op(20'sd1000, 5'sd7, 8, "pulse");
      count_valids(25, nv);
      check_val("pulse_extra_valid", nv, 0);

      // Reset at step 10 aborts the operation
      do_op(-20'sd77777, 5'sd3, -1, "pre_rst");
      @(negedge clk);
      div_en   = 1'b1;
      dividend = 20'sd99999;
      divisor  = 5'sd9;
      @(posedge clk);
      #1;
      div_en = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("abort_busy", {31'd0, div_busy}, 32'd0);
      check_val("abort_valid", {31'd0, div_out_valid}, 32'd0);
      check_val("abort_quot", {17'd0, quotient}, 32'd0);
      check_val("abort_rem", {27'd0, remainder}, 32'd0);
      check_val("abort_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      count_valids(25, nv);
      check_val("abort_no_valid", nv, 0);

      // Randomized back-to-back operations
      for (int i = 0; i < 2000; i++) begin
         sel = $urandom_range(0, 7);
         ra  = (sel == 0) ? dvd_corner[$urandom_range(0, 7)] : 20'($urandom);
         sel = $urandom_range(0, 7);
         if (sel == 0)      rb = 5'd0;
         else if (sel == 1) rb = dsr_corner[$urandom_range(0, 3)];
         else               rb = 5'($urandom);
         do_op(ra, rb, -1, "rnd");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
